// File: rtl/prog_logic_func_unit.sv
// Runtime-programmable multi-output truth-table unit: N_OUT functions of N_IN inputs,
// loaded beat-by-beat into a shadow buffer and committed atomically, with a 1-stage eval pipe.
module prog_logic_func_unit #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 4,
  parameter int CFG_W = 8,
  parameter logic [N_OUT*(2**N_IN)-1:0] INIT_TT = '0,
  localparam int TT     = 2**N_IN,
  localparam int BEATS  = TT / CFG_W,
  localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_abort,
  output logic             cfg_busy,
  output logic             cfg_done
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                      state_q, state_d;
  logic [BCNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [TT-1:0]               shadow_q, shadow_d;
  logic [N_OUT-1:0][TT-1:0]    active_q, active_d;
  logic                        done_q, done_d;
  logic                        out_valid_q, out_valid_d;
  logic [N_OUT-1:0]            out_data_q, out_data_d;

  logic                        commit_en;
  logic [SEL_W-1:0]            commit_sel;
  logic                        accept;
  logic [N_OUT-1:0]            lookup;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_ready = ~rst;
  assign cfg_busy  = (state_q == LOAD);
  assign cfg_done  = done_q;

  // Lookups read the registered active tables, so an eval on the commit edge sees the old table.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lookup
      assign lookup[gi] = active_q[gi][in_data];
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    done_d     = 1'b0;
    commit_en  = 1'b0;
    commit_sel = sel_q;

    if (state_q == IDLE) begin
      if (cfg_valid) begin
        shadow_d[CFG_W-1:0] = cfg_data;
        sel_d               = cfg_sel;
        if (BEATS == 1) begin
          commit_en  = 1'b1;
          commit_sel = cfg_sel;
        end else begin
          beat_cnt_d = BCNT_W'(1);
          state_d    = LOAD;
        end
      end
    end else begin
      // Abort takes priority; a beat presented alongside it is dropped.
      if (cfg_abort) begin
        beat_cnt_d = '0;
        state_d    = IDLE;
      end else if (cfg_valid) begin
        shadow_d[int'(beat_cnt_q)*CFG_W +: CFG_W] = cfg_data;
        if (beat_cnt_q == BCNT_W'(BEATS-1)) begin
          commit_en  = 1'b1;
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end

    // Out-of-range selects match no channel: the load completes without touching any table.
    if (commit_en) begin
      done_d = 1'b1;
      for (int k = 0; k < N_OUT; k++) begin
        if (commit_sel == SEL_W'(k)) active_d[k] = shadow_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      sel_q       <= '0;
      shadow_q    <= '0;
      active_q    <= INIT_TT;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_prog_logic_func_unit.sv
// Bench for prog_logic_func_unit: directed scenarios plus random traffic against a
// reference model holding whole truth tables and collecting config beats in a queue.
module tb_prog_logic_func_unit;

  localparam int N_IN  = 5;
  localparam int N_OUT = 4;
  localparam int CFG_W = 8;
  localparam int TT    = 32;
  localparam int BEATS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [N_IN-1:0]  in_data;
  logic [N_OUT-1:0] out_data;
  logic             cfg_valid, cfg_ready, cfg_abort, cfg_busy, cfg_done;
  logic [1:0]       cfg_sel;
  logic [CFG_W-1:0] cfg_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [TT-1:0]    m_tab [N_OUT];
  logic             m_ov;
  logic [N_OUT-1:0] m_od;
  logic             m_loading;
  logic             m_done;
  int               m_sel;
  logic [CFG_W-1:0] m_beats [$];

  prog_logic_func_unit #(.N_IN(N_IN), .N_OUT(N_OUT), .CFG_W(CFG_W), .INIT_TT('0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) m_tab[k] = '0;
    m_ov = 1'b0; m_od = '0; m_loading = 1'b0; m_done = 1'b0; m_sel = 0;
    m_beats.delete();
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_update();
    logic [TT-1:0] tt;
    if (in_valid && (!m_ov || out_ready)) begin
      m_ov = 1'b1;
      for (int k = 0; k < N_OUT; k++) m_od[k] = m_tab[k][in_data];
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    m_done = 1'b0;
    if (m_loading && cfg_abort) begin
      m_loading = 1'b0;
      m_beats.delete();
    end else if (cfg_valid) begin
      if (!m_loading) begin
        m_sel = int'(cfg_sel);
        m_loading = 1'b1;
      end
      m_beats.push_back(cfg_data);
      if (m_beats.size() == BEATS) begin
        tt = '0;
        for (int b = 0; b < BEATS; b++) tt = tt | (TT'(m_beats[b]) << (b*CFG_W));
        if (m_sel < N_OUT) m_tab[m_sel] = tt;
        m_done = 1'b1;
        m_loading = 1'b0;
        m_beats.delete();
      end
    end
  endtask

  // Called at a falling edge with inputs already set: check, advance model, wait one cycle.
  task automatic step();
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("in_ready",  32'(in_ready),  32'(!m_ov || out_ready));
    chk("cfg_busy",  32'(cfg_busy),  32'(m_loading));
    chk("cfg_done",  32'(cfg_done),  32'(m_done));
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
    $display("cyc t=%0t iv=%0b id=%0h or=%0b ov=%0b od=%0h cv=%0b cs=%0d cd=%0h ab=%0b busy=%0b done=%0b",
             $time, in_valid, in_data, out_ready, out_valid, out_data,
             cfg_valid, cfg_sel, cfg_data, cfg_abort, cfg_busy, cfg_done);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0; cfg_abort = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_cfg_busy",  32'(cfg_busy),  32'd0);
    chk("rst_cfg_done",  32'(cfg_done),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_beat(input logic [1:0] sel, input logic [7:0] data);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic eval(input logic [4:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_cfg_busy",  32'(cfg_busy),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: eval after reset, then reset mid-stream
    eval(5'h15);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'h0);
    in_valid = 1'b1; in_data = 5'h03; out_ready = 1'b0;
    step();
    do_reset();
    idle_inputs();
    step();

    // 2: ch0 = FFFF0000
    cfg_beat(2'd0, 8'h00); cfg_beat(2'd0, 8'h00); cfg_beat(2'd0, 8'hFF); cfg_beat(2'd0, 8'hFF);
    chk("t2_done", 32'(cfg_done), 32'd1);
    eval(5'h10);
    chk("t2_d10", 32'(out_data), 32'h1);
    chk("t2_done_once", 32'(cfg_done), 32'd0);
    eval(5'h0F);
    chk("t2_d0f", 32'(out_data), 32'h0);
    step();

    // 3: ch2 = AAAAAAAA, eval on the commit edge sees the old table
    cfg_beat(2'd2, 8'hAA); cfg_beat(2'd2, 8'hAA); cfg_beat(2'd2, 8'hAA);
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_data = 8'hAA;
    in_valid = 1'b1; in_data = 5'h01;
    step();
    cfg_valid = 1'b0;
    chk("t3_old_bit2", 32'(out_data[2]), 32'd0);
    step();
    chk("t3_new_bit2", 32'(out_data[2]), 32'd1);
    in_valid = 1'b0;
    step();

    // 4: backpressure then release
    in_valid = 1'b1; in_data = 5'h12;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 5'(i + 5'h1C);
      step();
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_held", 32'(out_data), 32'(m_od));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 5'(i * 7);
      step();
    end
    in_valid = 1'b0;
    step();

    // 5: abort together with the third beat
    cfg_beat(2'd1, 8'h11); cfg_beat(2'd1, 8'h22);
    cfg_valid = 1'b1; cfg_abort = 1'b1; cfg_data = 8'h33;
    step();
    cfg_valid = 1'b0; cfg_abort = 1'b0;
    chk("t5_busy", 32'(cfg_busy), 32'd0);
    step();
    for (int d = 0; d < 32; d++) eval(5'(d));
    cfg_beat(2'd1, 8'h0F); cfg_beat(2'd1, 8'hF0); cfg_beat(2'd1, 8'h3C); cfg_beat(2'd1, 8'hC3);
    for (int d = 0; d < 32; d++) eval(5'(d));

    // 6: reset after 3 beats, then full reload
    cfg_beat(2'd3, 8'h55); cfg_beat(2'd3, 8'h66); cfg_beat(2'd3, 8'h77);
    do_reset();
    idle_inputs();
    for (int d = 0; d < 32; d++) eval(5'(d));
    cfg_beat(2'd3, 8'h81); cfg_beat(2'd3, 8'h42); cfg_beat(2'd3, 8'h24); cfg_beat(2'd3, 8'h18);
    for (int d = 0; d < 32; d++) eval(5'(d));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 5'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_sel   = 2'($urandom);
      cfg_data  = 8'($urandom);
      cfg_abort = 1'($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
